// File: rtl/kf_phase_sequencer.sv
// Purpose : sequences the Kalman predict/update phases for programmable cycle counts.
// Latency : predict_en rises the cycle after the start edge; done follows the last enable cycle.
// Backpr. : no handshake; a start while busy is dropped and raises the sticky overrun flag.
//
// Ports:
//   clk, n_rst              - clock (rising edge) and async active-low reset
//   start, abort            - iteration request / synchronous abort
//   predict_len, update_len - phase lengths in cycles, latched on accepted start
//   busy, phase             - activity flag and current phase (0 IDLE,1 PREDICT,2 UPDATE,3 DONE)
//   predict_en, update_en   - per-cycle enables for the arithmetic units
//   cycle_idx               - 1-based cycle index within PREDICT/UPDATE, 0 otherwise
//   done, overrun           - completion pulse / sticky dropped-start flag
//   iter_count              - completed iterations, wrapping
module kf_phase_sequencer #(
  parameter int CNT_BITS = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_BITS-1:0] predict_len,
  input  logic [CNT_BITS-1:0] update_len,
  output logic                busy,
  output logic [1:0]          phase,
  output logic                predict_en,
  output logic                update_en,
  output logic [CNT_BITS-1:0] cycle_idx,
  output logic                done,
  output logic                overrun,
  output logic [CNT_BITS-1:0] iter_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PREDICT = 2'd1,
    S_UPDATE  = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [CNT_BITS-1:0] ZERO = '0;
  localparam logic [CNT_BITS-1:0] ONE  = CNT_BITS'(1);

  state_t              r_state;
  logic [CNT_BITS-1:0] r_cycle_idx;
  logic [CNT_BITS-1:0] r_p_len;
  logic [CNT_BITS-1:0] r_u_len;
  logic [CNT_BITS-1:0] r_iter_count;
  logic                r_overrun;

  state_t              w_state_nxt;
  logic [CNT_BITS-1:0] w_cycle_idx_nxt;
  logic [CNT_BITS-1:0] w_p_len_nxt;
  logic [CNT_BITS-1:0] w_u_len_nxt;
  logic [CNT_BITS-1:0] w_iter_count_nxt;
  logic                w_overrun_nxt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= S_IDLE;
      r_cycle_idx  <= ZERO;
      r_p_len      <= ZERO;
      r_u_len      <= ZERO;
      r_iter_count <= ZERO;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cycle_idx  <= w_cycle_idx_nxt;
      r_p_len      <= w_p_len_nxt;
      r_u_len      <= w_u_len_nxt;
      r_iter_count <= w_iter_count_nxt;
      r_overrun    <= w_overrun_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cycle_idx_nxt  = r_cycle_idx;
    w_p_len_nxt      = r_p_len;
    w_u_len_nxt      = r_u_len;
    w_iter_count_nxt = r_iter_count;
    w_overrun_nxt    = r_overrun;

    // A start outside IDLE is dropped but remembered, even if abort is also high.
    if (start && (r_state != S_IDLE)) begin
      w_overrun_nxt = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        // Abort takes priority over start in IDLE: nothing is accepted.
        if (start && !abort) begin
          w_p_len_nxt   = predict_len;
          w_u_len_nxt   = update_len;
          w_overrun_nxt = 1'b0;
          // Zero-length phases are skipped outright, so the first state
          // depends on the freshly sampled lengths, not the latched ones.
          if (predict_len != ZERO) begin
            w_state_nxt     = S_PREDICT;
            w_cycle_idx_nxt = ONE;
          end else if (update_len != ZERO) begin
            w_state_nxt     = S_UPDATE;
            w_cycle_idx_nxt = ONE;
          end else begin
            w_state_nxt     = S_DONE;
            w_cycle_idx_nxt = ZERO;
          end
        end
      end

      S_PREDICT: begin
        if (abort) begin
          w_state_nxt     = S_IDLE;
          w_cycle_idx_nxt = ZERO;
        end else if (r_cycle_idx == r_p_len) begin
          if (r_u_len != ZERO) begin
            w_state_nxt     = S_UPDATE;
            w_cycle_idx_nxt = ONE;
          end else begin
            w_state_nxt     = S_DONE;
            w_cycle_idx_nxt = ZERO;
          end
        end else begin
          // Equality exit above guarantees this never wraps, even at max length.
          w_cycle_idx_nxt = r_cycle_idx + ONE;
        end
      end

      S_UPDATE: begin
        if (abort) begin
          w_state_nxt     = S_IDLE;
          w_cycle_idx_nxt = ZERO;
        end else if (r_cycle_idx == r_u_len) begin
          w_state_nxt     = S_DONE;
          w_cycle_idx_nxt = ZERO;
        end else begin
          w_cycle_idx_nxt = r_cycle_idx + ONE;
        end
      end

      S_DONE: begin
        w_state_nxt     = S_IDLE;
        w_cycle_idx_nxt = ZERO;
        // An abort landing on DONE cancels the count, not the return to IDLE.
        if (!abort) begin
          w_iter_count_nxt = r_iter_count + ONE;
        end
      end

      default: begin
        w_state_nxt     = S_IDLE;
        w_cycle_idx_nxt = ZERO;
      end
    endcase
  end

  // All outputs are registers or decodes of the registered state.
  assign busy       = (r_state != S_IDLE);
  assign phase      = r_state;
  assign predict_en = (r_state == S_PREDICT);
  assign update_en  = (r_state == S_UPDATE);
  assign done       = (r_state == S_DONE);
  assign cycle_idx  = r_cycle_idx;
  assign overrun    = r_overrun;
  assign iter_count = r_iter_count;

endmodule

// File: tb/tb_kf_phase_sequencer.sv
module tb_kf_phase_sequencer;

  localparam int CB = 4;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          st, ab;
  logic [CB-1:0] pl, ul;
  logic          busy, predict_en, update_en, done, overrun;
  logic [1:0]    phase;
  logic [CB-1:0] cycle_idx, iter_count;

  int total = 0;
  int bad   = 0;

  // Reference model: an iteration is a timeline of P predict cycles, U update
  // cycles and one done cycle, indexed by m_t = cycles elapsed since the start edge.
  int m_act, m_t, m_p, m_u, m_iter, m_ovr;

  kf_phase_sequencer #(.CNT_BITS(CB)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (st),
    .abort      (ab),
    .predict_len(pl),
    .update_len (ul),
    .busy       (busy),
    .phase      (phase),
    .predict_en (predict_en),
    .update_en  (update_en),
    .cycle_idx  (cycle_idx),
    .done       (done),
    .overrun    (overrun),
    .iter_count (iter_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_t = 0; m_p = 0; m_u = 0; m_iter = 0; m_ovr = 0;
  endtask

  task automatic cmp_all();
    int e_ph, e_idx;
    e_ph = 0; e_idx = 0;
    if (m_act != 0) begin
      if (m_t <= m_p) begin
        e_ph = 1; e_idx = m_t;
      end else if (m_t <= m_p + m_u) begin
        e_ph = 2; e_idx = m_t - m_p;
      end else begin
        e_ph = 3;
      end
    end
    chk("busy",       32'(busy),       32'(m_act));
    chk("phase",      32'(phase),      32'(e_ph));
    chk("predict_en", 32'(predict_en), 32'(e_ph == 1));
    chk("update_en",  32'(update_en),  32'(e_ph == 2));
    chk("done",       32'(done),       32'(e_ph == 3));
    chk("cycle_idx",  32'(cycle_idx),  32'(e_idx));
    chk("overrun",    32'(overrun),    32'(m_ovr));
    chk("iter_count", 32'(iter_count), 32'(m_iter));
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic tick();
    @(posedge clk);
    if (m_act == 0) begin
      if (st && !ab) begin
        m_act = 1; m_t = 1; m_p = int'(pl); m_u = int'(ul); m_ovr = 0;
      end
    end else begin
      if (st) m_ovr = 1;
      if (ab) begin
        m_act = 0;
      end else if (m_t == m_p + m_u + 1) begin
        m_act = 0;
        m_iter = (m_iter + 1) % (1 << CB);
      end else begin
        m_t++;
      end
    end
    #1;
    cmp_all();
  endtask

  task automatic run_iter(input int p, input int u, output int pe_n, output int ue_n,
                          output int dn_n, output int busy_n);
    pe_n = 0; ue_n = 0; dn_n = 0; busy_n = 0;
    pl = CB'(p); ul = CB'(u); st = 1'b1;
    tick();
    st = 1'b0;
    for (int k = 0; k < p + u + 3; k++) begin
      pe_n += int'(predict_en);
      ue_n += int'(update_en);
      dn_n += int'(done);
      busy_n += int'(busy);
      tick();
    end
  endtask

  initial begin
    int pe_n, ue_n, dn_n, busy_n, it0;
    n_rst = 1'b0; st = 1'b0; ab = 1'b0; pl = '0; ul = '0;
    model_reset();
    #3;
    cmp_all();
    tick();
    n_rst = 1'b1;
    tick();

    // Nominal P=3,U=2.
    run_iter(3, 2, pe_n, ue_n, dn_n, busy_n);
    chk("nom_pe_cycles", pe_n, 3);
    chk("nom_ue_cycles", ue_n, 2);
    chk("nom_done_cycles", dn_n, 1);
    chk("nom_iter", 32'(iter_count), 1);

    // Zero-length phases.
    run_iter(0, 4, pe_n, ue_n, dn_n, busy_n);
    chk("p0_pe_cycles", pe_n, 0);
    chk("p0_ue_cycles", ue_n, 4);
    run_iter(0, 0, pe_n, ue_n, dn_n, busy_n);
    chk("zz_busy_cycles", busy_n, 1);
    chk("zz_done_cycles", dn_n, 1);

    // Start held through a run: overrun, then re-accept in first IDLE cycle.
    pl = 2; ul = 2; st = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    st = 1'b0;
    for (int k = 0; k < 8; k++) tick();

    // Abort at PREDICT cycle 2, then abort+start in IDLE.
    pl = 5; ul = 5; st = 1'b1;
    tick();
    st = 1'b0;
    tick();
    ab = 1'b1;
    tick();
    ab = 1'b0;
    chk("abort_phase", 32'(phase), 0);
    st = 1'b1; ab = 1'b1;
    tick();
    tick();
    st = 1'b0; ab = 1'b0;
    tick();

    // Maximum lengths.
    run_iter(15, 15, pe_n, ue_n, dn_n, busy_n);
    chk("max_pe_cycles", pe_n, 15);
    chk("max_ue_cycles", ue_n, 15);

    // Sixteen short iterations wrap the counter back to its start value.
    it0 = int'(iter_count);
    for (int n = 0; n < 16; n++) run_iter(1, 1, pe_n, ue_n, dn_n, busy_n);
    chk("iter_wrap", 32'(iter_count), 32'(it0));

    // Async reset in the middle of UPDATE.
    pl = 3; ul = 2; st = 1'b1;
    tick();
    st = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("pre_reset_phase", 32'(phase), 2);
    #2;
    n_rst = 1'b0;
    #1;
    model_reset();
    cmp_all();
    tick();
    n_rst = 1'b1;
    tick();
    run_iter(3, 2, pe_n, ue_n, dn_n, busy_n);
    chk("post_reset_busy", busy_n, 6);

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      st = ($urandom_range(0, 3) == 0);
      ab = ($urandom_range(0, 19) == 0);
      pl = ($urandom_range(0, 3) == 0) ? CB'($urandom_range(0, 15)) : CB'($urandom_range(0, 3));
      ul = ($urandom_range(0, 3) == 0) ? CB'($urandom_range(0, 15)) : CB'($urandom_range(0, 3));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kf_phase_sequencer.md
# kf_phase_sequencer

Cycle-accurate phase sequencer for the Kalman filter MCU datapath. On a start request it latches two programmable phase lengths and drives the predict and update enables for exactly that many clock cycles each. It then pulses `done` and counts completed iterations. An internal cycle counter runs within each phase; the block sits between the MCU control registers and the predict/update arithmetic units.

## Interface
Parameters:
- `CNT_BITS`, default 8: width of phase lengths, phase cycle counter and iteration counter.

Ports:
- `clk`  in  1: system clock, rising edge.
- `n_rst`  in  1: reset, asynchronous, active-low.
- `start`  in  1: iteration request, sampled every rising edge.
- `abort`  in  1: synchronous abort of the current iteration.
- `predict_len`  in  CNT_BITS: predict phase length in cycles, latched on accepted start.
- `update_len`  in  CNT_BITS: update phase length in cycles, latched on accepted start.
- `busy`  out  1: high in PREDICT, UPDATE and DONE.
- `phase`  out  2: 0 = IDLE, 1 = PREDICT, 2 = UPDATE, 3 = DONE.
- `predict_en`  out  1: high in every PREDICT cycle.
- `update_en`  out  1: high in every UPDATE cycle.
- `cycle_idx`  out  CNT_BITS: 1-based cycle index within the current phase; 0 in IDLE and DONE.
- `done`  out  1: single-cycle pulse on completion.
- `overrun`  out  1: sticky flag, start requested while busy.
- `iter_count`  out  CNT_BITS: number of completed iterations.

## Operation
- States: IDLE, PREDICT, UPDATE, DONE. All outputs are registered or decoded from registered state only; no combinational input-to-output path.
- Reset (n_rst low, async): state IDLE; cycle_idx, iter_count, latched lengths = 0; busy, predict_en, update_en, done, overrun = 0.
- Accepted start: `start`=1 and `abort`=0 in IDLE.
  - Latch both lengths and clear `overrun`.
  - Next state: PREDICT if P≠0; else UPDATE if U≠0; else DONE.
  - cycle_idx loads 1 when entering PREDICT or UPDATE.
- PREDICT:
  - If cycle_idx == P_latched, go to UPDATE (cycle_idx=1) when U≠0, else to DONE.
  - Otherwise cycle_idx increments.
- UPDATE: same rule against U_latched; exit to DONE.
- DONE: one cycle. `done`=1. Next state IDLE. `iter_count` increments on the DONE→IDLE transition and wraps 2^CNT_BITS−1 → 0.
- Length 0 skips that phase entirely (zero enable cycles). A length of 2^CNT_BITS−1 is legal; the counter never wraps within a phase.
- `start` while not IDLE is ignored and sets `overrun`. The flag holds until the next accepted start.
- `abort`=1 in any non-IDLE state:
  - Next state IDLE, cycle_idx=0.
  - No `done`, `iter_count` unchanged, latched lengths retained.
  - `abort` in IDLE has no effect. In IDLE, `abort`+`start` together: abort wins, start is not accepted, overrun is unchanged.
- Changes to `predict_len`/`update_len` after acceptance have no effect on the running iteration.

## Timing
- Let E0 be the rising edge that samples an accepted start, with P and U the latched lengths.
- `predict_en` is high for the P cycles following E0.
- `update_en` is high for the next U cycles.
- `done` is high for the single cycle after that.
- `busy` spans exactly P+U+1 cycles. A new start can be accepted on the edge that ends DONE+1, i.e. the first IDLE cycle. Back-to-back iterations therefore have a one-cycle IDLE gap.
- `predict_en` and `update_en` are never high in the same cycle. `done` never coincides with either enable.
- Async reset mid-phase: all outputs go to reset values immediately, independent of clk. The first start after reset release behaves as a fresh start.

## Test plan
- Reset: assert n_rst=0 mid-UPDATE → all outputs 0 and phase=0 without a clock edge; after release, start with P=3, U=2 → normal 6-cycle busy window.
- Nominal: P=3, U=2, start pulse → predict_en high 3 cycles with cycle_idx 1,2,3, then update_en 2 cycles with cycle_idx 1,2, then done 1 cycle; iter_count 0→1.
- Zero lengths: P=0, U=4 → no predict_en, update_en 4 cycles. P=0, U=0 → DONE immediately after the start edge (busy 1 cycle, done=1), iter_count increments.
- Overrun/ignore: start held high through a P=2, U=2 run → overrun=1 and the iteration still ends after 5 busy cycles; the held start is accepted in the first IDLE cycle and overrun clears.
- Abort: P=5, U=5, abort at PREDICT cycle_idx=2 → IDLE next cycle, no done, iter_count unchanged. Abort and start together in IDLE → remains IDLE.
- Wrap/max: CNT_BITS=4, P=15, U=15 → 15+15 enable cycles then done. Run 16 iterations of P=1, U=1 → iter_count returns to 0.
